// File: rtl/proj_defs.sv
// Shared definitions for the project datapath: operand width default, result
// width derivation and strobe bit positions in the controller's output vector.
package proj_defs;

    localparam int unsigned WIDTH_DEF = 8;

    // Order {A,B,C,D,en,valid}, MSB first, as the controller drives it.
    localparam int unsigned STB_W     = 6;
    localparam int unsigned STB_A     = 5;
    localparam int unsigned STB_B     = 4;
    localparam int unsigned STB_C     = 3;
    localparam int unsigned STB_D     = 2;
    localparam int unsigned STB_EN    = 1;
    localparam int unsigned STB_VALID = 0;

    // Two full-width products summed need one extra bit.
    function automatic int unsigned acc_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/dff.sv
// Register primitive with synchronous active-low clear and load enable.
module dff #(
    parameter int unsigned W = 1
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/result_fifo.sv
// Two-entry result FIFO built from dff registers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module result_fifo #(
    parameter int unsigned W = 17
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt_c;
    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         do_push_c;
    logic         do_pop_c;

    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);

    always_comb begin
        count_nxt_c = count;
        if (do_push_c && !do_pop_c) begin
            count_nxt_c = count + 2'd1;
        end else if (!do_push_c && do_pop_c) begin
            count_nxt_c = count - 2'd1;
        end
    end

    dff #(.W(1)) u_wr_ptr (.clock, .rst_n, .en(do_push_c), .d(~wr_ptr), .q(wr_ptr));
    dff #(.W(1)) u_rd_ptr (.clock, .rst_n, .en(do_pop_c),  .d(~rd_ptr), .q(rd_ptr));
    dff #(.W(2)) u_count  (.clock, .rst_n, .en(1'b1),      .d(count_nxt_c), .q(count));

    dff #(.W(W)) u_mem0 (.clock, .rst_n, .en(do_push_c && !wr_ptr), .d(din), .q(mem0));
    dff #(.W(W)) u_mem1 (.clock, .rst_n, .en(do_push_c &&  wr_ptr), .d(din), .q(mem1));

    assign dout  = rd_ptr ? mem1 : mem0;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/proj_datapath.sv
// Operand capture, RA*RB + RC*RD accumulate and result queueing driven by the
// controller's one-hot phase strobes.
module proj_datapath
    import proj_defs::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned ACC_W = acc_width(WIDTH)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             en,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    output logic             protocol_err
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    logic [STB_W-1:0]  stb_c;
    logic              multi_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic              full;
    logic              empty;
    logic [WIDTH-1:0]  ra;
    logic [WIDTH-1:0]  rb;
    logic [WIDTH-1:0]  rc;
    logic [WIDTH-1:0]  rd;
    logic [ACC_W-1:0]  acc;
    logic [PROD_W-1:0] prod_ab_c;
    logic [PROD_W-1:0] prod_cd_c;
    logic [ACC_W-1:0]  sum_c;

    always_comb begin
        stb_c            = '0;
        stb_c[STB_A]     = A;
        stb_c[STB_B]     = B;
        stb_c[STB_C]     = C;
        stb_c[STB_D]     = D;
        stb_c[STB_EN]    = en;
        stb_c[STB_VALID] = valid;
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_c = (stb_c & (stb_c - STB_W'(1))) != '0;

    assign prod_ab_c = PROD_W'(ra) * PROD_W'(rb);
    assign prod_cd_c = PROD_W'(rc) * PROD_W'(rd);
    assign sum_c     = ACC_W'(prod_ab_c) + ACC_W'(prod_cd_c);

    assign pop_c  = !empty && out_ready;
    assign push_c = valid && !multi_c;
    assign drop_c = push_c && full && !pop_c;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ra           <= '0;
            rb           <= '0;
            rc           <= '0;
            rd           <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (!multi_c) begin
                if (A)  ra  <= data_in;
                if (B)  rb  <= data_in;
                if (C)  rc  <= data_in;
                if (D)  rd  <= data_in;
                if (en) acc <= sum_c;
                if (B) begin
                    busy <= 1'b1;
                end else if (valid) begin
                    busy <= 1'b0;
                end
            end
            if (multi_c) protocol_err <= 1'b1;
            if (drop_c)  overflow     <= 1'b1;
        end
    end

    result_fifo #(.W(ACC_W)) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (acc),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_proj_datapath.sv
// Scoreboard bench for proj_datapath: a queue-based reference model predicts
// every accepted result and a negedge monitor checks outputs against it.
module tb_proj_datapath;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        A, B, C, D, en, valid, out_ready;
    logic [7:0]  data_in;
    logic [16:0] out_data;
    logic        out_valid, busy, overflow, protocol_err;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit rnd_ready = 1'b0;

    int unsigned m_ra, m_rb, m_rc, m_rd, m_acc;
    int unsigned m_q[$];
    int unsigned sb_q[$];
    int unsigned obs_q[$];
    bit m_busy, m_ovf, m_perr;

    always #5 clock = ~clock;

    proj_datapath #(.WIDTH(8)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .A            (A),
        .B            (B),
        .C            (C),
        .D            (D),
        .en           (en),
        .valid        (valid),
        .data_in      (data_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .overflow     (overflow),
        .protocol_err (protocol_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a bounded queue, results by plain arithmetic.
    always @(posedge clock) begin
        int  n;
        bit  pop;
        if (!rst_n) begin
            m_ra = 0; m_rb = 0; m_rc = 0; m_rd = 0; m_acc = 0;
            m_busy = 0; m_ovf = 0; m_perr = 0;
            m_q.delete();
            sb_q.delete();
        end else begin
            n   = int'(A) + int'(B) + int'(C) + int'(D) + int'(en) + int'(valid);
            pop = (m_q.size() != 0) && out_ready;
            if (pop) void'(m_q.pop_front());
            if (n > 1) begin
                m_perr = 1;
            end else begin
                if (A) m_ra = data_in;
                if (B) m_rb = data_in;
                if (C) m_rc = data_in;
                if (D) m_rd = data_in;
                if (en) m_acc = m_ra * m_rb + m_rc * m_rd;
                if (B) m_busy = 1;
                if (valid) begin
                    m_busy = 0;
                    if (m_q.size() < 2) begin
                        m_q.push_back(m_acc);
                        sb_q.push_back(m_acc);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    // Monitor: compare status every cycle, pop scoreboard on each handshake.
    always @(negedge clock) begin
        int unsigned exp;
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("busy", 32'(busy), 32'(m_busy));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("protocol_err", 32'(protocol_err), 32'(m_perr));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_data: got %0d, required no output (scoreboard empty)", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    check("out_data", 32'(out_data), exp);
                    obs_q.push_back(32'(out_data));
                end
            end
        end
    end

    task automatic step();
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        A = 0; B = 0; C = 0; D = 0; en = 0; valid = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic load_compute(input logic [7:0] a, b, c, d);
        idle(); A = 1; data_in = a; step();
        idle(); B = 1; data_in = b; step();
        idle(); C = 1; data_in = c; step();
        idle(); D = 1; data_in = d; step();
        idle(); en = 1; step();
        idle();
    endtask

    task automatic seq(input logic [7:0] a, b, c, d);
        load_compute(a, b, c, d);
        valid = 1; step();
        idle();
    endtask

    initial begin
        logic [5:0] vec;
        idle();
        rst_n = 0;
        out_ready = 0;
        data_in = '0;
        step();
        step();
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset busy", 32'(busy), 0);
        check("reset overflow", 32'(overflow), 0);
        check("reset protocol_err", 32'(protocol_err), 0);
        rst_n = 1;
        mon_en = 1;

        // Basic: A held three cycles, last value wins.
        out_ready = 1;
        A = 1; data_in = 9; step();
        check("idle busy", 32'(busy), 0);
        data_in = 9; step();
        data_in = 3; step();
        idle(); B = 1; data_in = 4; step();
        check("busy t2", 32'(busy), 1);
        idle(); C = 1; data_in = 5; step();
        idle(); D = 1; data_in = 6; step();
        idle(); en = 1; step();
        check("busy t5", 32'(busy), 1);
        check("out_valid t5", 32'(out_valid), 0);
        idle(); valid = 1; step();
        idle();
        check("basic out_valid t6", 32'(out_valid), 1);
        check("basic result", 32'(out_data), 42);
        check("busy t6", 32'(busy), 0);
        step();
        check("basic out_valid t7", 32'(out_valid), 0);

        // Max operands: no truncation.
        load_compute(8'd255, 8'd255, 8'd255, 8'd255);
        valid = 1; step(); idle();
        check("max result", 32'(out_data), 130050);
        step();

        // Back-pressure: third commit dropped.
        do_reset();
        out_ready = 0;
        seq(8'd2, 8'd3, 8'd0, 8'd0);
        seq(8'd1, 8'd1, 8'd1, 8'd1);
        seq(8'd7, 8'd7, 8'd0, 8'd0);
        check("bp overflow", 32'(overflow), 1);
        check("bp head", 32'(out_data), 6);
        out_ready = 1;
        step();
        check("bp second", 32'(out_data), 2);
        check("bp second valid", 32'(out_valid), 1);
        step();
        check("bp drained", 32'(out_valid), 0);

        // Full FIFO with simultaneous pop on commit.
        do_reset();
        out_ready = 0;
        seq(8'd1, 8'd2, 8'd0, 8'd0);
        seq(8'd3, 8'd3, 8'd0, 8'd0);
        obs_q.delete();
        load_compute(8'd2, 8'd2, 8'd1, 8'd1);
        valid = 1; out_ready = 1; step();
        idle();
        step(); step(); step();
        check("fullpop overflow", 32'(overflow), 0);
        check("fullpop count", 32'(obs_q.size()), 3);
        if (obs_q.size() == 3) begin
            check("fullpop first", obs_q[0], 2);
            check("fullpop second", obs_q[1], 9);
            check("fullpop third", obs_q[2], 5);
        end

        // Protocol error: C and D together must not load RC/RD.
        do_reset();
        out_ready = 1;
        seq(8'd2, 8'd3, 8'd4, 8'd5);
        step();
        C = 1; D = 1; data_in = 8'd77; step();
        idle();
        check("perr set", 32'(protocol_err), 1);
        en = 1; step(); idle();
        valid = 1; step(); idle();
        check("perr held operands", 32'(out_data), 26);
        step(); step();
        check("perr sticky", 32'(protocol_err), 1);

        // Reset mid-sequence with one result queued.
        out_ready = 0;
        seq(8'd1, 8'd1, 8'd0, 8'd0);
        idle(); A = 1; data_in = 2; step();
        idle(); B = 1; step();
        idle(); C = 1; step();
        idle(); D = 1; rst_n = 0; step();
        idle(); rst_n = 1;
        check("midrst out_valid", 32'(out_valid), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst overflow", 32'(overflow), 0);
        check("midrst protocol_err", 32'(protocol_err), 0);
        check("midrst out_data", 32'(out_data), 0);
        out_ready = 1;
        seq(8'd3, 8'd4, 8'd5, 8'd6);
        check("midrst fresh valid", 32'(out_valid), 1);
        check("midrst fresh result", 32'(out_data), 42);
        step();

        // Randomised sequences, random back-pressure, occasional stray strobes.
        do_reset();
        rnd_ready = 1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                vec = 6'($urandom_range(0, 63));
                {A, B, C, D, en, valid} = vec;
                data_in = 8'($urandom);
                step();
                idle();
            end else begin
                seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
        end
        rnd_ready = 0;
        out_ready = 1;
        step(); step(); step(); step();
        check("scoreboard drained", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proj_datapath.md
# proj_datapath

Arithmetic datapath directly downstream of the project controller. Consumes the controller's one-hot phase strobes (`A`, `B`, `C`, `D`, `en`, `valid`) and captures four operands from a shared input bus. Computes `RA*RB + RC*RD` and queues each result in a 2-entry output FIFO with a ready/valid handshake, so a stalled consumer does not lose results while the controller free-runs.

## Interface
- `WIDTH`, 8, operand width in bits.
- `ACC_W`, `2*WIDTH+1`, result width; derived, never overridden.
- `clock`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `A`, `B`, `C`, `D`  in  1 each  operand-load strobes for `RA`, `RB`, `RC`, `RD`.
- `en`  in  1  compute strobe.
- `valid`  in  1  result-commit strobe.
- `data_in`  in  WIDTH  unsigned operand bus, sampled on the edge where a load strobe is high.
- `out_data`  out  ACC_W  head of result FIFO.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.
- `busy`  out  1  a sequence is in flight.
- `overflow`  out  1  sticky; a commit was dropped.
- `protocol_err`  out  1  sticky; more than one strobe high in one cycle.

## Operation
- Reset (`rst_n`=0 at an edge): `RA`, `RB`, `RC`, `RD`, `ACC`, FIFO contents and pointers, `busy`, `overflow`, `protocol_err` all cleared. `out_data`=0, `out_valid`=0. Reset mid-sequence discards the partial sequence and all queued results.
- Load strobes: `A`→`RA`, `B`→`RB`, `C`→`RC`, `D`→`RD`, each loaded from `data_in`. `A` is asserted continuously while the controller idles; every such cycle reloads `RA`, and the last value before `B` is the one used.
- `en`: `ACC <= RA*RB + RC*RD`, unsigned, full precision. Max value is 2·(2^WIDTH−1)², which fits ACC_W with no truncation.
- `valid`: pushes `ACC` into the FIFO.
  - Full with no pop in the same cycle: the push is dropped, the FIFO is unchanged, and `overflow` is set.
  - Full with a simultaneous pop: the push succeeds.
- Pop on `out_valid && out_ready`; the head advances next cycle. `out_ready` while empty is a no-op.
- `busy`: set on the edge after `B`, cleared on the edge after `valid`. Reading 0 in idle makes repeated `A` harmless.
- Strobe check: if two or more of `A`–`D`, `en`, `valid` are high in one cycle, `protocol_err` is set. No operand, `ACC`, or FIFO-push update occurs that cycle; pops still proceed.
- `overflow` and `protocol_err` clear only on reset.
- An `en` with no new operands recomputes from the held registers. A `valid` with no preceding `en` commits the held `ACC`; this is legal and is not an error.

## Timing
- Controller sequence: `A`(t0) `B`(t1) `C`(t2) `D`(t3) `en`(t4) `valid`(t5).
- `RD` is visible at t4, `ACC` at t5, and the FIFO entry at t6.
- With the FIFO empty and `out_ready`=1: `out_valid`=1 during t6, then the entry pops at the end of t6.
- Latency from the `D` cycle to `out_valid` is 3 cycles. There is no bypass from `ACC` to `out_data`.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- FIFO throughput is one push and one pop per cycle. The controller produces at most one result per 6 cycles.

## Structure
- Shared package/header `proj_defs`: `WIDTH` default, `ACC_W` derivation, and strobe bit positions for `{A,B,C,D,en,valid}` matching the controller's output vector ordering.
- Sub-module `result_fifo`:
  - Parameterised width, depth 2.
  - Ports: push, pop, din, dout, full, empty.
  - Internal 1-bit read/write pointers plus a count.
  - Built from the existing `dff` register primitive.
- Operand registers, `ACC`, and status flags live in `proj_datapath` top.

## Test plan
- Basic: idle with `A` held 3 cycles (`data_in`=9,9,3), then `B`=4, `C`=5, `D`=6, `en`, `valid`, `out_ready`=1 → `out_data`=42 with `out_valid` high exactly one cycle at t6; `busy` high t2–t5.
- Max values: all operands 255 → `out_data`=130050 (17'h1FC02); no truncation.
- Back-pressure: `out_ready`=0, run three sequences (2·3+0·0=6, 1·1+1·1=2, 7·7=49) → FIFO holds 6, 2; third commit dropped; `overflow`=1. Then raise `out_ready` → 6 then 2 on consecutive cycles; `out_valid`=0 after.
- Full plus simultaneous pop: FIFO full, `valid` coincides with a pop → push accepted, `overflow` stays 0, and the new result emerges after the remaining entry.
- Protocol error: `C` and `D` high together with `data_in`=77 → `protocol_err`=1; `RC`/`RD` unchanged; sticky until reset.
- Reset mid-sequence: `rst_n`=0 at t3 with one result queued → next cycle `out_valid`=0, `busy`=0, flags 0. A fresh sequence then produces the correct result.
